// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter slice.
package dmem_arb_pkg;

  localparam int AW_DEF  = 9;
  localparam int DW_DEF  = 32;
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  typedef struct packed {
    logic              we;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] wdata;
  } req_t;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Memory-side bus between the arbiter (master) and the single-port DataMem (slave).
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_rr_picker.sv
// Combinational 2-way request picker; DMEM_ARB_FIXED_PRIO_EN selects fixed port-0 priority.
module dmem_rr_picker (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       valid,
  output logic       id
);
  assign valid = |req;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ptr;
  assign id         = ~req[0];
`else
  // On a tie the pointer decides; otherwise the lone requester wins.
  assign id = (&req) ? ptr : req[1];
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port DataMem: one access per 3 cycles.
// Round-robin by default; define DMEM_ARB_FIXED_PRIO_EN for fixed port-0 priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_err,
  dmem_arbiter_if.master mem
);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  state_e                     state_q, state_d;
  cmd_t                       cmd_q, cmd_d, pick_cmd;
  logic                       id_q, id_d;
  logic                       rr_ptr, pick_valid, pick_id;
  logic [NUM_REQ-1:0]         gnt_q, gnt_d, rvalid_q, rvalid_d, err_q, err_d;
  logic [NUM_REQ-1:0][DW-1:0] rdata_q, rdata_d;
  logic                       mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [AW-1:0]              mem_addr_q, mem_addr_d;
  logic [DW-1:0]              mem_wdata_q, mem_wdata_d;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign rr_ptr = 1'b0;
`else
  logic rr_ptr_q;

  // The port just served loses the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                rr_ptr_q <= 1'b0;
    else if (state_q == RESP)  rr_ptr_q <= ~id_q;
  end
  assign rr_ptr = rr_ptr_q;
`endif

  dmem_rr_picker u_picker (
    .req   ({p1_req, p0_req}),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .id    (pick_id)
  );

  assign pick_cmd = pick_id ? cmd_t'{p1_we, p1_addr, p1_wdata}
                            : cmd_t'{p0_we, p0_addr, p0_wdata};

  // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    id_d        = id_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d        = ACCESS;
          cmd_d          = pick_cmd;
          id_d           = pick_id;
          gnt_d[pick_id] = 1'b1;
          mem_addr_d     = pick_cmd.addr;
          mem_wdata_d    = pick_cmd.wdata;
          // Misaligned accesses are granted but never reach the memory.
          mem_read_d     = is_aligned(pick_cmd.addr[1:0]) && !pick_cmd.we;
          mem_write_d    = is_aligned(pick_cmd.addr[1:0]) &&  pick_cmd.we;
        end
      end
      ACCESS: begin
        state_d         = RESP;
        rvalid_d[id_q]  = 1'b1;
        err_d[id_q]     = !is_aligned(cmd_q.addr[1:0]);
        rdata_d[id_q]   = (cmd_q.we || err_d[id_q]) ? '0 : mem.mem_rdata;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q       <= '0;
      id_q        <= 1'b0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      err_q       <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      cmd_q       <= cmd_d;
      id_q        <= id_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign p0_gnt        = gnt_q[0];
  assign p0_rvalid     = rvalid_q[0];
  assign p0_rdata      = rdata_q[0];
  assign p0_err        = err_q[0];
  assign p1_gnt        = gnt_q[1];
  assign p1_rvalid     = rvalid_q[1];
  assign p1_rdata      = rdata_q[1];
  assign p1_err        = err_q[1];
  assign mem.mem_read  = mem_read_q;
  assign mem.mem_write = mem_write_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: transaction-level model, per-cycle compare, directed + random traffic.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req   [2];
  logic        we    [2];
  logic [8:0]  addr  [2];
  logic [31:0] wdata [2];
  logic        gnt   [2];
  logic        rvalid[2];
  logic [31:0] rdata [2];
  logic        err   [2];

  logic [31:0] dmem    [128];
  logic [31:0] ref_mem [128];

  int n_compared = 0;
  int n_mismatch = 0;
  int gnt_log[$];

  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(9), .DW(32)) mem_if ();

  dmem_arbiter #(.AW(9), .DW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p0_req    (req[0]),
    .p0_we     (we[0]),
    .p0_addr   (addr[0]),
    .p0_wdata  (wdata[0]),
    .p0_gnt    (gnt[0]),
    .p0_rvalid (rvalid[0]),
    .p0_rdata  (rdata[0]),
    .p0_err    (err[0]),
    .p1_req    (req[1]),
    .p1_we     (we[1]),
    .p1_addr   (addr[1]),
    .p1_wdata  (wdata[1]),
    .p1_gnt    (gnt[1]),
    .p1_rvalid (rvalid[1]),
    .p1_rdata  (rdata[1]),
    .p1_err    (err[1]),
    .mem       (mem_if)
  );

  // DataMem stand-in: combinational read, write committed on the clock edge.
  assign mem_if.mem_rdata = dmem[mem_if.mem_addr[8:2]];
  always @(posedge clk)
    if (mem_if.mem_write) dmem[mem_if.mem_addr[8:2]] <= mem_if.mem_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_compared++;
    if (act !== exp_v) begin
      n_mismatch++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------- reference model: one access occupies a 3-cycle slot ----------------
  int          m_slot = 0;      // cycles left in the current slot after acceptance
  int          m_win = 0;
  int          m_prefer = 0;
  logic [31:0] m_rsp_data = '0;
  logic        m_rsp_err = 1'b0;
  logic        e_gnt[2]    = '{1'b0, 1'b0};
  logic        e_rvalid[2] = '{1'b0, 1'b0};
  logic [31:0] e_rdata[2]  = '{32'd0, 32'd0};
  logic        e_err[2]    = '{1'b0, 1'b0};
  logic        e_read = 1'b0, e_write = 1'b0;
  logic [8:0]  e_addr = '0;
  logic [31:0] e_wdata = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_slot = 0; m_prefer = 0;
      e_gnt = '{1'b0, 1'b0}; e_rvalid = '{1'b0, 1'b0};
      e_rdata = '{32'd0, 32'd0}; e_err = '{1'b0, 1'b0};
      e_read = 1'b0; e_write = 1'b0; e_addr = '0; e_wdata = '0;
    end else begin
      req_t r;
      logic misal;
      e_gnt = '{1'b0, 1'b0}; e_rvalid = '{1'b0, 1'b0};
      e_read = 1'b0; e_write = 1'b0;
      if (m_slot == 0) begin
        if (req[0] || req[1]) begin
          if (req[0] && req[1]) m_win = FIXED ? 0 : m_prefer;
          else                  m_win = req[1] ? 1 : 0;
          r          = '{we[m_win], addr[m_win], wdata[m_win]};
          misal      = (r.addr % 4) != 0;
          e_gnt[m_win] = 1'b1;
          e_addr     = r.addr;
          e_wdata    = r.wdata;
          e_read     = !misal && !r.we;
          e_write    = !misal &&  r.we;
          m_rsp_err  = misal;
          m_rsp_data = (misal || r.we) ? 32'd0 : ref_mem[r.addr / 4];
          if (e_write) ref_mem[r.addr / 4] = r.wdata;
          m_slot = 2;
        end
      end else if (m_slot == 2) begin
        e_rvalid[m_win] = 1'b1;
        e_rdata[m_win]  = m_rsp_data;
        e_err[m_win]    = m_rsp_err;
        m_slot = 1;
      end else begin
        m_slot   = 0;
        m_prefer = 1 - m_win;
      end
    end
  end

  // ---------------- per-cycle compare, away from the active edge ----------------
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      check($sformatf("p%0d_gnt", p),    32'(gnt[p]),    32'(e_gnt[p]));
      check($sformatf("p%0d_rvalid", p), 32'(rvalid[p]), 32'(e_rvalid[p]));
      check($sformatf("p%0d_rdata", p),  rdata[p],       e_rdata[p]);
      check($sformatf("p%0d_err", p),    32'(err[p]),    32'(e_err[p]));
    end
    check("mem_read",  32'(mem_if.mem_read),  32'(e_read));
    check("mem_write", 32'(mem_if.mem_write), 32'(e_write));
    if (!rst_n || e_read || e_write) check("mem_addr", 32'(mem_if.mem_addr), 32'(e_addr));
    if (!rst_n || e_write)           check("mem_wdata", mem_if.mem_wdata, e_wdata);
  end

  always @(negedge clk)
    if (rst_n) for (int p = 0; p < 2; p++) if (gnt[p]) gnt_log.push_back(p);

  // Requester: raise req, drop it in the gnt cycle, return in the rvalid cycle.
  task automatic port_access(input int p, input logic w, input logic [8:0] a, input logic [31:0] d,
                             output logic [31:0] rd, output logic er,
                             output logic s_rd, output logic s_wr, output logic [8:0] s_addr);
    int n;
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!gnt[p] && n < 200);
    check($sformatf("p%0d_gnt_wait", p), 32'(gnt[p]), 32'd1);
    req[p] = 1'b0;
    s_rd = mem_if.mem_read; s_wr = mem_if.mem_write; s_addr = mem_if.mem_addr;
    rd = '0; er = 1'b0;
    if (!gnt[p]) return;
    @(negedge clk);
    check($sformatf("p%0d_rvalid_latency", p), 32'(rvalid[p]), 32'd1);
    rd = rdata[p]; er = err[p];
  endtask

  task automatic random_port(input int p, input int count);
    logic [31:0] rd; logic er, s_rd, s_wr; logic [8:0] s_a, a;
    for (int i = 0; i < count; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a = {7'($urandom_range(0, 127)), 2'b00};
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      port_access(p, 1'($urandom_range(0, 1)), a, $urandom, rd, er, s_rd, s_wr, s_a);
    end
  endtask

  initial begin
    logic [31:0] rd; logic er, s_rd, s_wr; logic [8:0] s_a;
    int n;
    for (int i = 0; i < 128; i++) begin dmem[i] = $urandom; ref_mem[i] = dmem[i]; end
    for (int p = 0; p < 2; p++) begin req[p] = 0; we[p] = 0; addr[p] = '0; wdata[p] = '0; end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset with random inputs toggling
    repeat (4) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        req[p] = 1'($urandom); we[p] = 1'($urandom); addr[p] = 9'($urandom); wdata[p] = $urandom;
      end
    end
    @(negedge clk);
    for (int p = 0; p < 2; p++) req[p] = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_mem_read",  32'(mem_if.mem_read),  32'd0);
    check("post_rst_mem_write", 32'(mem_if.mem_write), 32'd0);
    check("post_rst_p1_rdata",  rdata[1],              32'd0);

    // Port 0 store then load of 0x010
    port_access(0, 1'b1, 9'h010, 32'hDEADBEEF, rd, er, s_rd, s_wr, s_a);
    check("st_mem_write", 32'(s_wr), 32'd1);
    check("st_mem_addr",  32'(s_a),  32'h010);
    check("st_rdata",     rd,        32'd0);
    port_access(0, 1'b0, 9'h010, 32'd0, rd, er, s_rd, s_wr, s_a);
    check("ld_mem_read",  32'(s_rd), 32'd1);
    check("ld_rdata",     rd,        32'hDEADBEEF);
    check("ld_err",       32'(er),   32'd0);

    // Port 1 misaligned load
    port_access(1, 1'b0, 9'h013, 32'd0, rd, er, s_rd, s_wr, s_a);
    check("mis_mem_read", 32'(s_rd), 32'd0);
    check("mis_err",      32'(er),   32'd1);
    check("mis_rdata",    rd,        32'd0);

    // Both ports held: four accesses each, re-requesting immediately
    gnt_log.delete();
    fork
      for (int i = 0; i < 4; i++)
        port_access(0, 1'b0, 9'(9'h100 + 4 * i), 32'd0, rd, er, s_rd, s_wr, s_a);
      begin
        logic [31:0] rd1; logic er1, r1, w1; logic [8:0] a1;
        for (int i = 0; i < 4; i++)
          port_access(1, 1'b0, 9'(9'h180 + 4 * i), 32'd0, rd1, er1, r1, w1, a1);
      end
    join
    check("order_len", 32'(gnt_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < gnt_log.size(); i++)
      check($sformatf("order_%0d", i), 32'(gnt_log[i]), FIXED ? 32'(i >= 4) : 32'(i % 2));

    // Reset during ACCESS of a port 1 load
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 9'h040;
    n = 0;
    do begin @(negedge clk); n++; end while (!gnt[1] && n < 50);
    check("rst_mid_gnt_wait", 32'(gnt[1]), 32'd1);
    req[1] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_p1_gnt",   32'(gnt[1]),          32'd0);
    check("rst_mid_mem_read", 32'(mem_if.mem_read), 32'd0);
    check("rst_mid_mem_addr", 32'(mem_if.mem_addr), 32'd0);
    check("rst_mid_p0_rdata", rdata[0],             32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    port_access(0, 1'b0, 9'h010, 32'd0, rd, er, s_rd, s_wr, s_a);
    check("after_rst_ld_rdata", rd, 32'hDEADBEEF);

    // Random concurrent traffic
    fork
      random_port(0, 40);
      random_port(1, 40);
    join
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
